tof_echo_detector: RTL and testbench
====================================

Name: tof_echo_detector

Overview:
- Sits directly downstream of the FIR matched-filter / normalised-match stage.
- Consumes the per-sample match decision and the transmitter burst-start event.
- Measures time-of-flight as the number of filtered samples from burst start to the first confirmed echo.
- Reports one result per burst: either a TOF count or a timeout. Results go to the 7-seg display and the MBED readout.

Parameters:
- CNT_W, 16, width of the sample index and of TOF_COUNT.
- BLANK_SAMPLES, 64, samples after burst start during which MATCH is ignored (direct TX-to-RX coupling).
- MAX_SAMPLES, 3800, sample index limit per burst (≈14 ms listen window); must be > BLANK_SAMPLES + CONFIRM_N.
- CONFIRM_N, 3, number of consecutive matching samples needed to accept an echo; valid range 1..15.

Ports:
- CLK_FAST  in  1  system clock (70 MHz).
- RST  in  1  synchronous reset, active-high.
- ON  in  1  system enable; low forces IDLE.
- BURST_START  in  1  single-cycle pulse, synchronous to CLK_FAST, marks the first TX pulse of a burst.
- SAMPLE_VALID  in  1  single-cycle strobe, one per filtered sample (FIR_SOURCE_VALID).
- MATCH  in  1  match decision; sampled only when SAMPLE_VALID=1.
- TOF_COUNT  out  CNT_W  sample index of the first sample of the confirmed run; held until the next TOF_VALID.
- TOF_VALID  out  1  single-cycle pulse when TOF_COUNT is updated.
- TIMEOUT  out  1  single-cycle pulse when the listen window expires with no echo.
- BUSY  out  1  high in BLANK, SEARCH and CONFIRM.
- OVERRUN  out  1  sticky flag: a burst started before the previous measurement finished. Cleared only by RST.
- STATE  out  3  current state encoding, for LEDs.

Behaviour:
- Reset: RST=1 at a clock edge sets the following on the next cycle:
  - State = IDLE.
  - TOF_COUNT=0, TOF_VALID=0, TIMEOUT=0, BUSY=0, OVERRUN=0, STATE=0.
  - Sample index = 0, run counter = 0.
  - RST mid-measurement discards it; no report is issued.
- ON=0: forces IDLE, BUSY=0 and the run counter to 0 on the next cycle. TOF_COUNT and OVERRUN are held. No pulses are issued.
- State encoding: IDLE=0, BLANK=1, SEARCH=2, CONFIRM=3, REPORT=4.
- Sample index: set to 0 on BURST_START; incremented by 1 on each SAMPLE_VALID while BUSY. The index of a sample is its value before the increment, so the first sample after a burst has index 0.
- IDLE:
  - BURST_START & ON → BLANK.
  - SAMPLE_VALID is ignored.
- BLANK:
  - MATCH is ignored.
  - When a sample with index BLANK_SAMPLES-1 is processed → SEARCH.
- SEARCH, on SAMPLE_VALID with MATCH=1:
  - Latch the candidate index = current sample index; run counter = 1.
  - If CONFIRM_N=1 → REPORT; otherwise → CONFIRM.
- CONFIRM, on SAMPLE_VALID:
  - MATCH=1: run counter +1. When it reaches CONFIRM_N → REPORT.
  - MATCH=0: run counter = 0 → SEARCH. The candidate index is discarded.
- REPORT:
  - Lasts exactly one cycle. TOF_COUNT ← candidate index, TOF_VALID=1.
  - Then → IDLE.
- Latency: TOF_VALID asserts the cycle after the SAMPLE_VALID cycle that completes confirmation.
- Timeout:
  - Applies in BLANK, SEARCH or CONFIRM.
  - When the sample with index MAX_SAMPLES-1 is processed and does not complete confirmation: TIMEOUT=1 for the following cycle, then → IDLE. TOF_COUNT is unchanged.
  - If that same sample completes confirmation, TOF_VALID is issued and TIMEOUT is not.
- BURST_START while BUSY:
  - OVERRUN ← 1; the measurement is abandoned with no report.
  - Index ← 0, run counter ← 0 → BLANK.
  - A BURST_START during REPORT is accepted after the report: the report completes, then the state goes to BLANK and OVERRUN is not set.
- BURST_START and SAMPLE_VALID in the same cycle: the burst takes priority and the sample is neither counted nor evaluated.
- The index counter saturates at 2^CNT_W-1. This is unreachable with legal parameters.
- TOF_VALID and TIMEOUT are never high in the same cycle and are never high in consecutive cycles for the same burst.

Test Plan (BLANK_SAMPLES=64, MAX_SAMPLES=3800, CONFIRM_N=3; SAMPLE_VALID every 4 cycles):
- Basic echo:
  - Stimulus: burst, then MATCH=1 on samples 500–502 and 0 elsewhere.
  - Response: TOF_VALID pulses once, one cycle after the SAMPLE_VALID of sample 502; TOF_COUNT=500; BUSY falls; no TIMEOUT.
- Blanking, then timeout:
  - Stimulus: burst, then MATCH=1 on samples 5–60 only.
  - Response: no TOF_VALID; TIMEOUT pulses one cycle after sample 3799; TOF_COUNT keeps its prior value.
- Broken run:
  - Stimulus: MATCH=1 on samples 500–501, 0 on 502, 1 on 600–602.
  - Response: TOF_COUNT=600; exactly one TOF_VALID.
- Window edge:
  - Stimulus: MATCH=1 on samples 3797–3799.
  - Response: TOF_VALID with TOF_COUNT=3797; TIMEOUT stays 0.
- Overrun and collision:
  - Stimulus: second BURST_START at sample index 300 of the first burst, in the same cycle as a SAMPLE_VALID; then MATCH=1 on samples 100–102 of the new burst.
  - Response: OVERRUN=1 (stays 1); TOF_COUNT=100.
- Reset and enable mid-operation:
  - Stimulus: RST in CONFIRM after 2 matches.
  - Response: all outputs 0 next cycle; following SAMPLE_VALIDs are ignored until BURST_START.
  - Stimulus: ON=0 in SEARCH.
  - Response: state goes to IDLE; TOF_COUNT is held.

Source files
------------

// File: rtl/tof_echo_detector.sv
// rtl/tof_echo_detector.sv - time-of-flight echo detector: burst start to first confirmed match run
module tof_echo_detector #(
    parameter int CNT_W         = 16,
    parameter int BLANK_SAMPLES = 64,
    parameter int MAX_SAMPLES   = 3800,
    parameter int CONFIRM_N     = 3
) (
    input  logic             CLK_FAST,
    input  logic             RST,
    input  logic             ON,
    input  logic             BURST_START,
    input  logic             SAMPLE_VALID,
    input  logic             MATCH,
    output logic [CNT_W-1:0] TOF_COUNT,
    output logic             TOF_VALID,
    output logic             TIMEOUT,
    output logic             BUSY,
    output logic             OVERRUN,
    output logic [2:0]       STATE
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] BLANK   = 3'd1;
    localparam logic [2:0] SEARCH  = 3'd2;
    localparam logic [2:0] CONFIRM = 3'd3;
    localparam logic [2:0] REPORT  = 3'd4;

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_SAMPLES - 1);
    localparam logic [CNT_W-1:0] MAX_LAST   = CNT_W'(MAX_SAMPLES - 1);
    localparam logic [3:0]       RUN_TARGET = 4'(CONFIRM_N);

    logic [2:0]       state;
    logic [CNT_W-1:0] idx;
    logic [CNT_W-1:0] cand;
    logic [3:0]       run;
    logic [3:0]       run_next;
    logic             done;
    logic [CNT_W-1:0] hit_index;

    assign run_next = run + 4'd1;

    // The sample being processed completes the confirmation run.
    always_comb begin
        done      = 1'b0;
        hit_index = cand;
        if (MATCH) begin
            if (state == SEARCH && CONFIRM_N == 1) begin
                done      = 1'b1;
                hit_index = idx;
            end else if (state == CONFIRM && run_next == RUN_TARGET) begin
                done = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK_FAST) begin
        if (RST) begin
            state     <= IDLE;
            idx       <= '0;
            cand      <= '0;
            run       <= '0;
            TOF_COUNT <= '0;
            TOF_VALID <= 1'b0;
            TIMEOUT   <= 1'b0;
            OVERRUN   <= 1'b0;
        end else begin
            TOF_VALID <= 1'b0;
            TIMEOUT   <= 1'b0;
            if (!ON) begin
                state <= IDLE;
                run   <= '0;
            end else begin
                case (state)
                    IDLE, REPORT: begin
                        // A burst arriving during REPORT starts cleanly once the report is out.
                        if (BURST_START) begin
                            state <= BLANK;
                            idx   <= '0;
                            run   <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    BLANK, SEARCH, CONFIRM: begin
                        if (BURST_START) begin
                            OVERRUN <= 1'b1;
                            state   <= BLANK;
                            idx     <= '0;
                            run     <= '0;
                        end else if (SAMPLE_VALID) begin
                            if (idx != '1)
                                idx <= idx + 1'b1;
                            if (done) begin
                                TOF_VALID <= 1'b1;
                                TOF_COUNT <= hit_index;
                                state     <= REPORT;
                                run       <= '0;
                            end else if (idx == MAX_LAST) begin
                                TIMEOUT <= 1'b1;
                                state   <= IDLE;
                                run     <= '0;
                            end else begin
                                case (state)
                                    BLANK: begin
                                        if (idx == BLANK_LAST)
                                            state <= SEARCH;
                                    end
                                    SEARCH: begin
                                        if (MATCH) begin
                                            cand  <= idx;
                                            run   <= 4'd1;
                                            state <= CONFIRM;
                                        end
                                    end
                                    CONFIRM: begin
                                        if (MATCH) begin
                                            run <= run_next;
                                        end else begin
                                            run   <= '0;
                                            state <= SEARCH;
                                        end
                                    end
                                    default: ;
                                endcase
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        run   <= '0;
                    end
                endcase
            end
        end
    end

    assign BUSY  = (state == BLANK) || (state == SEARCH) || (state == CONFIRM);
    assign STATE = state;

endmodule

// File: tb/tb_tof_echo_detector.sv
// tb/tb_tof_echo_detector.sv - directed self-checking bench for tof_echo_detector
module tb_tof_echo_detector;

    logic        clk_fast = 1'b0;
    logic        rst = 1'b1;
    logic        on = 1'b1;
    logic        burst_start = 1'b0;
    logic        sample_valid = 1'b0;
    logic        match = 1'b0;
    logic [15:0] tof_count;
    logic        tof_valid;
    logic        timeout;
    logic        busy;
    logic        overrun;
    logic [2:0]  state;

    int n_tests = 0;
    int n_fail  = 0;
    int tv_cnt  = 0;
    int to_cnt  = 0;
    int both_cnt = 0;
    int tv0, to0;
    logic       last_tv, last_to;
    logic [2:0] last_state;

    tof_echo_detector #(
        .CNT_W(16), .BLANK_SAMPLES(64), .MAX_SAMPLES(3800), .CONFIRM_N(3)
    ) dut (
        .CLK_FAST(clk_fast), .RST(rst), .ON(on), .BURST_START(burst_start),
        .SAMPLE_VALID(sample_valid), .MATCH(match), .TOF_COUNT(tof_count),
        .TOF_VALID(tof_valid), .TIMEOUT(timeout), .BUSY(busy),
        .OVERRUN(overrun), .STATE(state)
    );

    always #5 clk_fast = ~clk_fast;

    always @(negedge clk_fast) begin
        if (tof_valid) tv_cnt <= tv_cnt + 1;
        if (timeout) to_cnt <= to_cnt + 1;
        if (tof_valid && timeout) both_cnt <= both_cnt + 1;
    end

    task automatic tick();
        @(posedge clk_fast);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic burst();
        burst_start = 1'b1;
        tick();
        burst_start = 1'b0;
    endtask

    task automatic send_sample(input logic m);
        sample_valid = 1'b1;
        match = m;
        tick();
        last_tv = tof_valid;
        last_to = timeout;
        last_state = state;
        sample_valid = 1'b0;
        match = 1'b0;
        repeat (3) tick();
    endtask

    task automatic run(input int from, input int upto, input logic m);
        for (int i = from; i <= upto; i++) send_sample(m);
    endtask

    initial begin
        repeat (3) tick();
        rst = 1'b0;
        check("reset_tof_count", tof_count, 0);
        check("reset_tof_valid", tof_valid, 0);
        check("reset_timeout", timeout, 0);
        check("reset_busy", busy, 0);
        check("reset_overrun", overrun, 0);
        check("reset_state", state, 0);

        // basic echo at 500..502
        tv0 = tv_cnt; to0 = to_cnt;
        burst();
        check("basic_blank_state", state, 1);
        check("basic_busy", busy, 1);
        run(0, 62, 1'b0);
        check("blank_last_minus1", last_state, 1);
        run(63, 63, 1'b0);
        check("blank_to_search", last_state, 2);
        run(64, 499, 1'b0);
        run(500, 501, 1'b1);
        check("basic_confirm_state", last_state, 3);
        run(502, 502, 1'b1);
        check("basic_tof_valid_latency", last_tv, 1);
        check("basic_report_state", last_state, 4);
        check("basic_tof_count", tof_count, 500);
        check("basic_busy_after", busy, 0);
        check("basic_state_idle", state, 0);
        check("basic_tv_pulses", tv_cnt - tv0, 1);
        check("basic_no_timeout", to_cnt - to0, 0);

        // matches only inside blanking, then timeout
        tv0 = tv_cnt; to0 = to_cnt;
        burst();
        run(0, 4, 1'b0);
        run(5, 60, 1'b1);
        run(61, 3798, 1'b0);
        check("timeout_search_before_end", last_state, 2);
        run(3799, 3799, 1'b0);
        check("timeout_pulse_latency", last_to, 1);
        check("timeout_no_tv", last_tv, 0);
        check("timeout_state_idle", last_state, 0);
        check("timeout_tof_held", tof_count, 500);
        check("timeout_tv_pulses", tv_cnt - tv0, 0);
        check("timeout_to_pulses", to_cnt - to0, 1);

        // broken run
        tv0 = tv_cnt;
        burst();
        run(0, 499, 1'b0);
        run(500, 501, 1'b1);
        run(502, 502, 1'b0);
        check("broken_back_to_search", last_state, 2);
        run(503, 599, 1'b0);
        run(600, 602, 1'b1);
        check("broken_tv", last_tv, 1);
        check("broken_tof_count", tof_count, 600);
        check("broken_tv_pulses", tv_cnt - tv0, 1);

        // confirmation completes on the last sample of the window
        tv0 = tv_cnt; to0 = to_cnt;
        burst();
        run(0, 3796, 1'b0);
        run(3797, 3799, 1'b1);
        check("edge_tv", last_tv, 1);
        check("edge_no_timeout", last_to, 0);
        check("edge_tof_count", tof_count, 3797);
        check("edge_tv_pulses", tv_cnt - tv0, 1);
        check("edge_to_pulses", to_cnt - to0, 0);

        // overrun with burst colliding with a sample
        burst();
        run(0, 299, 1'b0);
        check("pre_overrun", overrun, 0);
        burst_start = 1'b1; sample_valid = 1'b1; match = 1'b1;
        tick();
        burst_start = 1'b0; sample_valid = 1'b0; match = 1'b0;
        check("overrun_set", overrun, 1);
        check("overrun_state_blank", state, 1);
        repeat (3) tick();
        run(0, 99, 1'b0);
        run(100, 102, 1'b1);
        check("overrun_tof_count", tof_count, 100);
        check("overrun_sticky", overrun, 1);

        // reset in CONFIRM after two matches
        burst();
        run(0, 99, 1'b0);
        run(100, 101, 1'b1);
        check("rst_pre_confirm", state, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_state", state, 0);
        check("rst_mid_tof_count", tof_count, 0);
        check("rst_mid_overrun", overrun, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_pulses", {30'd0, tof_valid, timeout}, 0);
        tv0 = tv_cnt;
        run(0, 9, 1'b1);
        check("rst_samples_ignored", state, 0);
        check("rst_no_tv", tv_cnt - tv0, 0);

        // first searchable samples, then ON=0 in SEARCH
        burst();
        run(0, 63, 1'b0);
        run(64, 66, 1'b1);
        check("first_search_tof", tof_count, 64);
        burst();
        run(0, 99, 1'b0);
        check("on_pre_search", state, 2);
        on = 1'b0;
        tick();
        check("on_off_state", state, 0);
        check("on_off_busy", busy, 0);
        check("on_off_tof_held", tof_count, 64);
        on = 1'b1;
        tv0 = tv_cnt;
        run(0, 5, 1'b1);
        check("on_stays_idle", state, 0);
        check("on_no_tv", tv_cnt - tv0, 0);
        check("never_both_pulses", both_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
